// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared types and constants for the microwave keypad time-entry path.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } kp_state_t;

  localparam logic [3:0] BCD_NONE   = 4'hF;
  localparam int         NUM_DIGITS = 4;

  // Codes A..F from the encoder are treated exactly like "no key".
  function automatic logic key_present(input logic [3:0] d, input logic none);
    return !none && (d <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad encoder / entry-buffer signal bundle between the controller and its neighbours.
interface keypad_entry_ctrl_if;
  logic [3:0] key_d;
  logic       key_none;
  logic       entry_en;
  logic       clear_entry;
  logic       enc_enablen;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       digit_strobe;
  logic       entry_full;
  logic       entry_nonzero;

  modport master (
    output key_d, key_none, entry_en, clear_entry,
    input  enc_enablen, sec_ones, sec_tens, min_ones, min_tens,
           digit_strobe, entry_full, entry_nonzero
  );

  modport slave (
    input  key_d, key_none, entry_en, clear_entry,
    output enc_enablen, sec_ones, sec_tens, min_ones, min_tens,
           digit_strobe, entry_full, entry_nonzero
  );
endinterface

// File: rtl/keypad_entry_ctrl_debounce.sv
// Press/release debouncer: yields one accept pulse per debounced key press.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_d,
  input  logic       key_none,
  input  logic       entry_en,
  output logic       accept,
  output logic [3:0] digit
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  kp_state_t       state, state_nxt;
  logic [DB_W-1:0] cnt, cnt_nxt;
  logic [3:0]      cand, cand_nxt;
  logic            present;

  assign present = key_present(key_d, key_none);
  assign digit   = cand;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Candidate digit is pure data; it is always reloaded before it is used.
  always_ff @(posedge clk) begin
    cand <= cand_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (!entry_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (present) begin
            state_nxt = DEBOUNCE;
            cand_nxt  = key_d;
            cnt_nxt   = '0;
          end
        end
        DEBOUNCE: begin
          if (!present) begin
            state_nxt = IDLE;
          end else if (key_d != cand) begin
            cand_nxt = key_d;
            cnt_nxt  = '0;
          end else if (cnt == CNT_LAST) begin
            accept    = 1'b1;
            state_nxt = WAIT_RELEASE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          // Any key sample restarts the release run, so holding never re-triggers.
          if (present) begin
            cnt_nxt = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Microwave time-entry controller: debounced keypad digits shift into an MM:SS BCD buffer.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic               clk,
  input  logic               rst,
  keypad_entry_ctrl_if.slave bus
);

  localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

  logic                          accept;
  logic [3:0]                    acc_digit;
  logic [NUM_DIGITS-1:0][3:0]    digits;
  logic [2:0]                    count;
  logic                          strobe_p1;
  logic                          enc_n;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .key_d   (bus.key_d),
    .key_none(bus.key_none),
    .entry_en(bus.entry_en),
    .accept  (accept),
    .digit   (acc_digit)
  );

  // digits[0] is seconds ones; a new digit enters there and pushes the rest left.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits    <= '0;
      count     <= '0;
      strobe_p1 <= 1'b0;
      enc_n     <= 1'b1;
    end else begin
      enc_n     <= !bus.entry_en;
      strobe_p1 <= 1'b0;
      if (bus.entry_en) begin
        if (bus.clear_entry) begin
          digits <= '0;
          count  <= '0;
        end else if (accept && count != FULL_CNT) begin
          strobe_p1 <= 1'b1;
          // A leading zero is acknowledged but leaves the buffer untouched.
          if (!(acc_digit == 4'd0 && count == 3'd0)) begin
            digits <= {digits[NUM_DIGITS-2:0], acc_digit};
            count  <= count + 3'd1;
          end
        end
      end
    end
  end

  assign bus.enc_enablen   = enc_n;
  assign bus.sec_ones      = digits[0];
  assign bus.sec_tens      = digits[1];
  assign bus.min_ones      = digits[2];
  assign bus.min_tens      = digits[3];
  assign bus.digit_strobe  = strobe_p1;
  assign bus.entry_full    = (count == FULL_CNT);
  assign bus.entry_nonzero = |digits;

endmodule
